carbonio_irq_sched: RTL and testbench

CARBONIO_IRQ_SCHED -- requirements
Module: carbonio_irq_sched

---
 rtl/carbonio_irq_sched_if.sv | 37 +++
 rtl/carbonio_irq_sched.sv | 140 ++++++++++++++
 tb/tb_carbonio_irq_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/carbonio_irq_sched_if.sv
// Purpose : bundles the scheduler's source, config, CPU and router signals.
// Latency : n/a (signal bundle only).
// Backpressure: none; irq_valid is held until irq_ack or withdrawal.
// Ports   : master = environment side (router, CPU, config); slave = scheduler side.
interface carbonio_irq_sched_if #(
  parameter int N_SOURCES = 8,
  parameter int PRIO_W    = 2
);
  localparam int VEC_W = $clog2(N_SOURCES);

  logic [N_SOURCES-1:0] pending;
  logic [N_SOURCES-1:0] enable;
  logic                 cfg_we;
  logic [VEC_W-1:0]     cfg_idx;
  logic [PRIO_W-1:0]    cfg_prio;
  logic                 irq_valid;
  logic [VEC_W-1:0]     irq_vector;
  logic [PRIO_W-1:0]    irq_prio;
  logic                 irq_ack;
  logic                 eoi;
  logic                 clr_valid;
  logic [VEC_W-1:0]     clr_vector;
  logic                 in_service;
  logic [7:0]           spurious_cnt;

  modport master (
    output pending, enable, cfg_we, cfg_idx, cfg_prio, irq_ack, eoi,
    input  irq_valid, irq_vector, irq_prio, clr_valid, clr_vector,
           in_service, spurious_cnt
  );

  modport slave (
    input  pending, enable, cfg_we, cfg_idx, cfg_prio, irq_ack, eoi,
    output irq_valid, irq_vector, irq_prio, clr_valid, clr_vector,
           in_service, spurious_cnt
  );
endinterface

// File: rtl/carbonio_irq_sched.sv
// Purpose : priority + round-robin interrupt scheduler with present/ack/eoi handshake.
// Latency : irq_valid rises one cycle after a candidate is visible in IDLE.
// Backpressure: a presented interrupt is held frozen until acked or withdrawn.
// Ports   : clk, rst_n (async active-low); bus (slave modport) carries pending/enable,
//           priority-table writes, CPU irq/ack/eoi, router clear pulse, spurious count.
module carbonio_irq_sched #(
  parameter int N_SOURCES = 8,
  parameter int PRIO_W    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  carbonio_irq_sched_if.slave  bus
);
  localparam int VEC_W = $clog2(N_SOURCES);
  localparam int SW    = VEC_W + 1;
  localparam logic [VEC_W:0]   N_L  = SW'(N_SOURCES);
  localparam logic [VEC_W-1:0] LAST = VEC_W'(N_SOURCES - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t               state;
  logic [PRIO_W-1:0]    prio_tbl [N_SOURCES];
  logic [VEC_W-1:0]     rr_ptr;
  logic                 irq_valid_q;
  logic [VEC_W-1:0]     irq_vector_q;
  logic [PRIO_W-1:0]    irq_prio_q;
  logic                 clr_valid_q;
  logic [VEC_W-1:0]     clr_vector_q;
  logic                 in_service_q;
  logic [7:0]           spur_q;

  logic [N_SOURCES-1:0] cand;
  logic                 any_cand;
  logic [VEC_W-1:0]     win;
  logic [PRIO_W-1:0]    win_prio;
  logic [VEC_W:0]       scan_sum;
  logic [VEC_W-1:0]     scan_idx;
  logic                 ack_spur;
  logic                 eoi_spur;
  logic [8:0]           spur_sum;
  logic [7:0]           spur_next;

  assign cand = bus.pending & bus.enable;

  // Walk the sources in round-robin order starting at rr_ptr; only a strictly
  // higher priority displaces the current pick, so among equal top priorities
  // the first one reached from rr_ptr wins.
  always_comb begin
    any_cand = 1'b0;
    win      = '0;
    win_prio = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int off = 0; off < N_SOURCES; off++) begin
      scan_sum = {1'b0, rr_ptr} + SW'(off);
      if (scan_sum >= N_L) scan_sum = scan_sum - N_L;
      scan_idx = scan_sum[VEC_W-1:0];
      if (cand[scan_idx] && (!any_cand || (prio_tbl[scan_idx] > win_prio))) begin
        any_cand = 1'b1;
        win      = scan_idx;
        win_prio = prio_tbl[scan_idx];
      end
    end
  end

  // Each ignored pulse counts separately, so an ack and an eoi that are both
  // out of place in the same cycle add two.
  assign ack_spur  = bus.irq_ack && (state != PRESENT);
  assign eoi_spur  = bus.eoi && (state != SERVICE);
  assign spur_sum  = {1'b0, spur_q} + 9'(ack_spur) + 9'(eoi_spur);
  assign spur_next = spur_sum[8] ? 8'hFF : spur_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SOURCES; i++) prio_tbl[i] <= '0;
    end else if (bus.cfg_we && ({1'b0, bus.cfg_idx} < N_L)) begin
      prio_tbl[bus.cfg_idx] <= bus.cfg_prio;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      irq_valid_q  <= 1'b0;
      irq_vector_q <= '0;
      irq_prio_q   <= '0;
      clr_valid_q  <= 1'b0;
      clr_vector_q <= '0;
      in_service_q <= 1'b0;
      spur_q       <= '0;
    end else begin
      clr_valid_q <= 1'b0;
      spur_q      <= spur_next;
      case (state)
        IDLE: begin
          if (any_cand) begin
            state        <= PRESENT;
            irq_valid_q  <= 1'b1;
            irq_vector_q <= win;
            irq_prio_q   <= win_prio;
          end
        end
        PRESENT: begin
          // Ack takes precedence over a simultaneous withdrawal.
          if (bus.irq_ack) begin
            state        <= SERVICE;
            irq_valid_q  <= 1'b0;
            clr_valid_q  <= 1'b1;
            clr_vector_q <= irq_vector_q;
            in_service_q <= 1'b1;
            rr_ptr       <= (irq_vector_q == LAST) ? '0 : irq_vector_q + 1'b1;
          end else if (!cand[irq_vector_q]) begin
            state       <= IDLE;
            irq_valid_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state        <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          irq_valid_q  <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_valid    = irq_valid_q;
  assign bus.irq_vector   = irq_vector_q;
  assign bus.irq_prio     = irq_prio_q;
  assign bus.clr_valid    = clr_valid_q;
  assign bus.clr_vector   = clr_vector_q;
  assign bus.in_service   = in_service_q;
  assign bus.spurious_cnt = spur_q;
endmodule

// File: tb/tb_carbonio_irq_sched.sv
// Purpose : self-checking bench for carbonio_irq_sched (N_SOURCES=8, PRIO_W=2).
// Latency : one tick per clock; outputs sampled 1ns after the rising edge.
// Backpressure: n/a.
module tb_carbonio_irq_sched;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  carbonio_irq_sched_if #(.N_SOURCES(N), .PRIO_W(2)) bus ();

  carbonio_irq_sched #(.N_SOURCES(N), .PRIO_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: abstract scheduler state kept as plain ints/arrays.
  int m_state;  // 0 idle, 1 presenting, 2 in service
  int m_rr;
  int m_tbl [N];
  int m_vec, m_prio, m_clr_vec, m_spur;
  bit m_clr;

  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] en;
    logic       we;
    logic [2:0] idx;
    logic [1:0] p;
    logic       ack;
    logic       eoi;
    logic       valid;
    logic [2:0] vec;
    logic [1:0] prio;
    logic       clr_v;
    logic [2:0] clr_vec;
    logic       insvc;
    logic [7:0] spur;
  } row_t;

  function automatic row_t row(int pend, int en, int we, int idx, int p, int ack, int eoi,
                               int valid, int vec, int prio, int clr_v, int clr_vec,
                               int insvc, int spur);
    row_t r;
    r.pend = 8'(pend); r.en = 8'(en); r.we = 1'(we); r.idx = 3'(idx); r.p = 2'(p);
    r.ack = 1'(ack); r.eoi = 1'(eoi); r.valid = 1'(valid); r.vec = 3'(vec);
    r.prio = 2'(prio); r.clr_v = 1'(clr_v); r.clr_vec = 3'(clr_vec);
    r.insvc = 1'(insvc); r.spur = 8'(spur);
    return r;
  endfunction

  function automatic logic [31:0] dut_pack();
    return {13'd0, bus.irq_valid, bus.irq_vector, bus.irq_prio, bus.clr_valid,
            bus.clr_vector, bus.in_service, bus.spurious_cnt};
  endfunction

  function automatic logic [31:0] model_pack();
    return {13'd0, 1'(m_state == 1), 3'(m_vec), 2'(m_prio), 1'(m_clr),
            3'(m_clr_vec), 1'(m_state == 2), 8'(m_spur)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rr = 0; m_vec = 0; m_prio = 0; m_clr = 0; m_clr_vec = 0; m_spur = 0;
    for (int i = 0; i < N; i++) m_tbl[i] = 0;
  endtask

  // Highest priority among candidates, then first such source at or after m_rr.
  function automatic int model_arb(logic [7:0] cand);
    int best = -1;
    for (int i = 0; i < N; i++) if (cand[i] && m_tbl[i] > best) best = m_tbl[i];
    for (int k = 0; k < N; k++) begin
      if (cand[(m_rr + k) % N] && m_tbl[(m_rr + k) % N] == best) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(logic [7:0] pend, logic [7:0] en, logic we, logic [2:0] idx,
                            logic [1:0] p, logic ack, logic eoi);
    logic [7:0] cand;
    int w;
    cand  = pend & en;
    m_clr = 0;
    if (ack && m_state != 1) m_spur++;
    if (eoi && m_state != 2) m_spur++;
    if (m_spur > 255) m_spur = 255;
    if (m_state == 0) begin
      w = model_arb(cand);
      if (w >= 0) begin
        m_state = 1; m_vec = w; m_prio = m_tbl[w];
      end
    end else if (m_state == 1) begin
      if (ack) begin
        m_state = 2; m_clr = 1; m_clr_vec = m_vec; m_rr = (m_vec + 1) % N;
      end else if (!cand[m_vec]) begin
        m_state = 0;
      end
    end else if (eoi) begin
      m_state = 0;
    end
    if (we && int'(idx) < N) m_tbl[idx] = int'(p);
  endtask

  task automatic tick();
    logic [7:0] pend, en;
    logic we, ack, eoi;
    logic [2:0] idx;
    logic [1:0] p;
    pend = bus.pending; en = bus.enable; we = bus.cfg_we; idx = bus.cfg_idx;
    p = bus.cfg_prio; ack = bus.irq_ack; eoi = bus.eoi;
    @(posedge clk);
    #1;
    model_step(pend, en, we, idx, p, ack, eoi);
    check("model", dut_pack(), model_pack());
  endtask

  task automatic drive(logic [7:0] pend, logic [7:0] en, logic we, logic [2:0] idx,
                       logic [1:0] p, logic ack, logic eoi);
    bus.pending = pend; bus.enable = en; bus.cfg_we = we; bus.cfg_idx = idx;
    bus.cfg_prio = p; bus.irq_ack = ack; bus.eoi = eoi;
  endtask

  row_t tbl [23];

  initial begin
    vectors = 0;
    miscompares = 0;
    // pend en we idx p ack eoi | valid vec prio clr clr_vec insvc spur
    tbl[0]  = row(8'h00, 8'hFF, 1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(8'h00, 8'hFF, 1, 5, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = row(8'h24, 8'hFF, 0, 0, 0, 0, 0,  1, 5, 3, 0, 0, 0, 0);
    tbl[3]  = row(8'h24, 8'hFF, 0, 0, 0, 1, 0,  0, 5, 3, 1, 5, 1, 0);
    tbl[4]  = row(8'h24, 8'hFF, 0, 0, 0, 0, 1,  0, 5, 3, 0, 5, 0, 0);
    tbl[5]  = row(8'h24, 8'hFF, 0, 0, 0, 0, 0,  1, 5, 3, 0, 5, 0, 0);
    tbl[6]  = row(8'h00, 8'hFF, 0, 0, 0, 0, 0,  0, 5, 3, 0, 5, 0, 0);
    tbl[7]  = row(8'h09, 8'hFF, 1, 5, 0, 0, 0,  1, 0, 0, 0, 5, 0, 0);
    tbl[8]  = row(8'h09, 8'hFF, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0);
    tbl[9]  = row(8'h09, 8'hFF, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[10] = row(8'h09, 8'hFF, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0);
    tbl[11] = row(8'h09, 8'hFF, 0, 0, 0, 1, 0,  0, 3, 0, 1, 3, 1, 0);
    tbl[12] = row(8'h09, 8'hFF, 0, 0, 0, 0, 1,  0, 3, 0, 0, 3, 0, 0);
    tbl[13] = row(8'h09, 8'hFF, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0, 0);
    tbl[14] = row(8'h09, 8'hFF, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0);
    tbl[15] = row(8'h09, 8'hFF, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[16] = row(8'h09, 8'hFF, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0);
    tbl[17] = row(8'h09, 8'hFF, 0, 0, 0, 1, 0,  0, 3, 0, 1, 3, 1, 0);
    tbl[18] = row(8'h10, 8'hFF, 0, 0, 0, 0, 1,  0, 3, 0, 0, 3, 0, 0);
    tbl[19] = row(8'h10, 8'hFF, 0, 0, 0, 0, 0,  1, 4, 0, 0, 3, 0, 0);
    tbl[20] = row(8'h10, 8'hEF, 0, 0, 0, 0, 0,  0, 4, 0, 0, 3, 0, 0);
    tbl[21] = row(8'h10, 8'hEF, 0, 0, 0, 0, 0,  0, 4, 0, 0, 3, 0, 0);
    tbl[22] = row(8'h00, 8'hFF, 0, 0, 0, 1, 0,  0, 4, 0, 0, 3, 0, 1);

    rst_n = 1'b0;
    drive(8'h00, 8'hFF, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_state", dut_pack(), 32'd0);
    rst_n = 1'b1;

    // Directed table: priority win, round-robin 0,3,0,3, withdraw, spurious ack.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].pend, tbl[i].en, tbl[i].we, tbl[i].idx, tbl[i].p, tbl[i].ack, tbl[i].eoi);
      tick();
      check($sformatf("table[%0d]", i), dut_pack(),
            {13'd0, tbl[i].valid, tbl[i].vec, tbl[i].prio, tbl[i].clr_v,
             tbl[i].clr_vec, tbl[i].insvc, tbl[i].spur});
    end

    // eoi while presenting is ignored and counted.
    drive(8'h02, 8'hFF, 0, 0, 0, 0, 0);
    tick();
    check("present_vec1", {30'd0, bus.irq_valid, bus.irq_vector == 3'd1}, 32'd3);
    drive(8'h02, 8'hFF, 0, 0, 0, 0, 1);
    tick();
    check("eoi_in_present", {23'd0, bus.irq_valid, bus.spurious_cnt}, {23'd0, 1'b1, 8'd2});

    // Config write while presenting leaves the latched priority alone.
    drive(8'h02, 8'hFF, 1, 1, 2, 0, 0);
    tick();
    check("cfg_during_present", {30'd0, bus.irq_prio}, 32'd0);

    drive(8'h02, 8'hFF, 0, 0, 0, 1, 0);
    tick();
    check("in_service", {31'd0, bus.in_service}, 32'd1);

    // Asynchronous reset mid-service, source still pending afterwards.
    drive(8'h02, 8'hFF, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset_async", dut_pack(), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    check("represent_after_reset", {28'd0, bus.irq_valid, bus.irq_vector}, {28'd0, 1'b1, 3'd1});

    // Withdraw, then 300 spurious ack pulses in IDLE.
    drive(8'h00, 8'hFF, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 300; i++) begin
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      tick();
    end
    check("spurious_saturate", {22'd0, bus.irq_valid, bus.in_service, bus.spurious_cnt},
          {22'd0, 1'b0, 1'b0, 8'd255});

    // Randomized traffic against the reference model.
    model_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive(8'($urandom) & 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF,
            1'($urandom_range(0, 3) == 0), 3'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
